// File: rtl/vram_writer_pkg.sv
// Shared definitions for the VRAM write port: default memory widths (also
// used by the VGA top) and the drain FSM state encoding.
package vram_writer_pkg;

   localparam int SYS_DATA_WIDTH_DEF = 16;
   localparam int SYS_ADDR_WIDTH_DEF = 16;
   localparam int LOG2_DEPTH_DEF     = 3;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_VS = 2'd1,
      DRAIN   = 2'd2
   } wr_state_t;

endpackage

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO holding pending {addr,data} write entries.
// Pointers carry an extra wrap bit so full and empty are distinguishable.
module vram_wr_fifo #(
   parameter int WIDTH      = 32,
   parameter int LOG2_DEPTH = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty
);

   localparam int DEPTH = 1 << LOG2_DEPTH;

   logic [WIDTH-1:0]    mem [DEPTH];
   logic [LOG2_DEPTH:0] wr_ptr;
   logic [LOG2_DEPTH:0] rd_ptr;
   logic                push_ok;
   logic                pop_ok;

   assign full    = (wr_ptr[LOG2_DEPTH] != rd_ptr[LOG2_DEPTH]) &&
                    (wr_ptr[LOG2_DEPTH-1:0] == rd_ptr[LOG2_DEPTH-1:0]);
   assign empty   = (wr_ptr == rd_ptr);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign rd_data = mem[rd_ptr[LOG2_DEPTH-1:0]];

   // Pointer update; reset discards every queued entry.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + {{LOG2_DEPTH{1'b0}}, 1'b1};
         if (pop_ok)  rd_ptr <= rd_ptr + {{LOG2_DEPTH{1'b0}}, 1'b1};
      end
   end

   // Entry storage; contents are only meaningful between the pointers.
   always_ff @(posedge clk) begin
      if (reset && push_ok) mem[wr_ptr[LOG2_DEPTH-1:0]] <= wr_data;
   end

endmodule

// File: rtl/vram_writer.sv
// Write-side port of the shared tile/glyph memory. CPU writes are queued and
// only drained to memory while vertical sync is active, so the display never
// scans out a partially updated frame.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | queue empty, nothing to do
// WAIT_VS | entries queued, waiting for the sync window to open
// DRAIN   | window open, popping one entry per cycle
module vram_writer
   import vram_writer_pkg::*;
#(
   parameter int SYS_DATA_WIDTH = SYS_DATA_WIDTH_DEF,
   parameter int SYS_ADDR_WIDTH = SYS_ADDR_WIDTH_DEF,
   parameter int LOG2_DEPTH     = LOG2_DEPTH_DEF
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      req_valid,
   output logic                      req_ready,
   input  logic [SYS_ADDR_WIDTH-1:0] req_addr,
   input  logic [SYS_DATA_WIDTH-1:0] req_data,
   input  logic                      vga_vs,
   output logic                      mem_we,
   output logic [SYS_ADDR_WIDTH-1:0] mem_addr,
   output logic [SYS_DATA_WIDTH-1:0] mem_data,
   output logic                      pending,
   output logic                      frame_commit
);

   localparam int ENTRY_W = SYS_ADDR_WIDTH + SYS_DATA_WIDTH;

   wr_state_t          state_q;
   wr_state_t          state_d;
   logic               vs_q;
   logic               window_open;
   logic               pop;
   logic               commit;
   logic               fifo_full;
   logic               fifo_empty;
   logic [ENTRY_W-1:0] fifo_rd;

   // req_ready depends only on registered pointers, never on req_valid.
   assign req_ready    = !fifo_full;
   assign window_open  = !vs_q;
   assign pending      = !fifo_empty;
   assign frame_commit = commit;

   vram_wr_fifo #(
      .WIDTH      (ENTRY_W),
      .LOG2_DEPTH (LOG2_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .push    (req_valid),
      .wr_data ({req_addr, req_data}),
      .pop     (pop),
      .rd_data (fifo_rd),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   // Register vsync once; reset to the inactive (window closed) level.
   always_ff @(posedge clk) begin
      if (!reset) vs_q <= 1'b1;
      else        vs_q <= vga_vs;
   end

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!reset) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next state and pop decision. Popping from WAIT_VS lets the first pop land
   // on the first edge that sees the window open.
   always_comb begin
      state_d = state_q;
      pop     = 1'b0;
      commit  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) state_d = window_open ? DRAIN : WAIT_VS;
         end
         WAIT_VS: begin
            if (window_open) begin
               state_d = DRAIN;
               pop     = !fifo_empty;
            end
         end
         DRAIN: begin
            if (fifo_empty) begin
               state_d = IDLE;
               commit  = 1'b1;
            end else if (!window_open) begin
               state_d = WAIT_VS;
            end else begin
               pop = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Memory write port; address and data hold their last value when idle.
   always_ff @(posedge clk) begin
      if (!reset) begin
         mem_we   <= 1'b0;
         mem_addr <= '0;
         mem_data <= '0;
      end else begin
         mem_we <= pop;
         if (pop) {mem_addr, mem_data} <= fifo_rd;
      end
   end

endmodule

// File: tb/tb_vram_writer.sv
// Self-checking bench for vram_writer. Expected memory writes come from a
// queue of the requests the bench expects to be accepted, in order.
module tb_vram_writer;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_addr;
   logic [15:0] req_data;
   logic        vga_vs;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_data;
   logic        pending;
   logic        frame_commit;

   int          checks;
   int          failures;
   int          cyc;
   int          commit_cnt;
   logic [31:0] obs_q[$];
   int          obs_cyc[$];
   logic [31:0] model_q[$];

   vram_writer dut (
      .clk          (clk),
      .reset        (reset),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_data     (req_data),
      .vga_vs       (vga_vs),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_data     (mem_data),
      .pending      (pending),
      .frame_commit (frame_commit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   // Record every memory write and commit pulse as seen mid-cycle.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         obs_q.push_back({mem_addr, mem_data});
         obs_cyc.push_back(cyc);
      end
      if (frame_commit === 1'b1) commit_cnt++;
   end

   task automatic drive_req(input logic [15:0] a, input logic [15:0] d);
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = a;
      req_data  = d;
   endtask

   task automatic drop_req();
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic set_vs(input logic v, input int settle);
      @(negedge clk);
      vga_vs = v;
      repeat (settle) @(negedge clk);
   endtask

   task automatic wait_writes(input int n, input int budget);
      for (int i = 0; i < budget && obs_q.size() < n; i++) @(negedge clk);
      repeat (3) @(negedge clk);
   endtask

   task automatic clear_logs();
      obs_q.delete();
      obs_cyc.delete();
      model_q.delete();
   endtask

   task automatic test_reset();
      reset     = 1'b0;
      req_valid = 1'b1;
      req_addr  = 16'($urandom);
      req_data  = 16'($urandom);
      vga_vs    = 1'b0;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
         checks++;
         if (mem_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_mem_we got=%b want=0", mem_we);
         end
         checks++;
         if (pending !== 1'b0) begin
            failures++;
            $display("FAIL reset_pending got=%b want=0", pending);
         end
      end
      reset     = 1'b1;
      req_valid = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (pending !== 1'b0 || obs_q.size() != 0) begin
         failures++;
         $display("FAIL reset_no_entry pending=%b writes=%0d want 0/0", pending, obs_q.size());
      end
      checks++;
      if (req_ready !== 1'b1 || mem_addr !== 16'h0 || mem_data !== 16'h0 || commit_cnt != 0) begin
         failures++;
         $display("FAIL reset_outputs ready=%b addr=%h data=%h commits=%0d want 1/0/0/0",
                  req_ready, mem_addr, mem_data, commit_cnt);
      end
      clear_logs();
   endtask

   task automatic test_latency();
      int c0;
      c0 = commit_cnt;
      drive_req(16'h1234, 16'h5678);
      model_q.push_back({16'h1234, 16'h5678});
      @(negedge clk);
      req_valid = 1'b0;
      checks++;
      if (pending !== 1'b1 || mem_we !== 1'b0) begin
         failures++;
         $display("FAIL lat_n pending=%b mem_we=%b want 1/0", pending, mem_we);
      end
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0) begin
         failures++;
         $display("FAIL lat_n1 mem_we=%b want 0", mem_we);
      end
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b1 || {mem_addr, mem_data} !== model_q[0]) begin
         failures++;
         $display("FAIL lat_n2 mem_we=%b got=%h want=1/%h", mem_we, {mem_addr, mem_data}, model_q[0]);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (obs_q.size() != 1 || commit_cnt - c0 != 1 || pending !== 1'b0) begin
         failures++;
         $display("FAIL lat_done writes=%0d commits=%0d pending=%b want 1/1/0",
                  obs_q.size(), commit_cnt - c0, pending);
      end
      clear_logs();
   endtask

   task automatic test_deferred();
      int c0;
      set_vs(1'b1, 3);
      c0 = commit_cnt;
      drive_req(16'h0010, 16'hABCD);
      model_q.push_back({16'h0010, 16'hABCD});
      drop_req();
      repeat (20) @(negedge clk);
      checks++;
      if (obs_q.size() != 0 || pending !== 1'b1) begin
         failures++;
         $display("FAIL deferred_hold writes=%0d pending=%b want 0/1", obs_q.size(), pending);
      end
      set_vs(1'b0, 0);
      wait_writes(1, 20);
      checks++;
      if (obs_q.size() != 1) begin
         failures++;
         $display("FAIL deferred_count got=%0d want=1", obs_q.size());
      end else if (obs_q[0] !== model_q[0]) begin
         failures++;
         $display("FAIL deferred_value got=%h want=%h", obs_q[0], model_q[0]);
      end
      checks++;
      if (commit_cnt - c0 != 1) begin
         failures++;
         $display("FAIL deferred_commit got=%0d want=1", commit_cnt - c0);
      end
      clear_logs();
   endtask

   task automatic test_full();
      int c0;
      logic exp_rdy;
      logic [15:0] a, d;
      set_vs(1'b1, 3);
      c0 = commit_cnt;
      for (int i = 0; i < 9; i++) begin
         a = 16'($urandom);
         d = 16'($urandom);
         drive_req(a, d);
         exp_rdy = (i < 8);
         checks++;
         if (req_ready !== exp_rdy) begin
            failures++;
            $display("FAIL full_ready[%0d] got=%b want=%b", i, req_ready, exp_rdy);
         end
         if (exp_rdy) model_q.push_back({a, d});
      end
      repeat (3) @(negedge clk);
      checks++;
      if (req_ready !== 1'b0 || pending !== 1'b1) begin
         failures++;
         $display("FAIL full_hold ready=%b pending=%b want 0/1", req_ready, pending);
      end
      req_valid = 1'b0;
      set_vs(1'b0, 0);
      wait_writes(8, 30);
      checks++;
      if (obs_q.size() != model_q.size()) begin
         failures++;
         $display("FAIL full_count got=%0d want=%0d", obs_q.size(), model_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < model_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== model_q[i] || obs_cyc[i] != obs_cyc[0] + i) begin
            failures++;
            $display("FAIL full_order[%0d] got=%h@%0d want=%h@%0d", i, obs_q[i], obs_cyc[i],
                     model_q[i], obs_cyc[0] + i);
         end
      end
      checks++;
      if (commit_cnt - c0 != 1) begin
         failures++;
         $display("FAIL full_commit got=%0d want=1", commit_cnt - c0);
      end
      clear_logs();
   endtask

   task automatic test_window_close();
      int c0;
      logic [15:0] a, d;
      set_vs(1'b1, 3);
      c0 = commit_cnt;
      for (int i = 0; i < 8; i++) begin
         a = 16'($urandom);
         d = 16'($urandom);
         drive_req(a, d);
         model_q.push_back({a, d});
      end
      drop_req();
      @(negedge clk);
      vga_vs = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      vga_vs = 1'b1;
      repeat (10) @(negedge clk);
      checks++;
      if (obs_q.size() != 3 || commit_cnt != c0 || pending !== 1'b1) begin
         failures++;
         $display("FAIL wclose_first writes=%0d commits=%0d pending=%b want 3/0/1",
                  obs_q.size(), commit_cnt - c0, pending);
      end
      set_vs(1'b0, 0);
      wait_writes(8, 30);
      checks++;
      if (obs_q.size() != 8) begin
         failures++;
         $display("FAIL wclose_count got=%0d want=8", obs_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < 8; i++) begin
         checks++;
         if (obs_q[i] !== model_q[i]) begin
            failures++;
            $display("FAIL wclose_order[%0d] got=%h want=%h", i, obs_q[i], model_q[i]);
         end
      end
      checks++;
      if (commit_cnt - c0 != 1) begin
         failures++;
         $display("FAIL wclose_commit got=%0d want=1", commit_cnt - c0);
      end
      clear_logs();
   endtask

   task automatic test_push_pop();
      int c0;
      logic [15:0] a, d;
      set_vs(1'b1, 3);
      c0 = commit_cnt;
      for (int i = 0; i < 4; i++) begin
         a = 16'($urandom_range(0, 3));
         d = 16'($urandom);
         drive_req(a, d);
         model_q.push_back({a, d});
      end
      drop_req();
      @(negedge clk);
      vga_vs = 1'b0;
      for (int i = 0; i < 10; i++) begin
         a = 16'($urandom_range(0, 3));
         d = 16'($urandom);
         drive_req(a, d);
         checks++;
         if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL pp_ready[%0d] got=%b want=1", i, req_ready);
         end
         model_q.push_back({a, d});
      end
      drop_req();
      wait_writes(14, 40);
      checks++;
      if (obs_q.size() != model_q.size()) begin
         failures++;
         $display("FAIL pp_count got=%0d want=%0d", obs_q.size(), model_q.size());
      end
      for (int i = 0; i < obs_q.size() && i < model_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== model_q[i]) begin
            failures++;
            $display("FAIL pp_order[%0d] got=%h want=%h", i, obs_q[i], model_q[i]);
         end
      end
      checks++;
      if (commit_cnt - c0 != 1 || pending !== 1'b0) begin
         failures++;
         $display("FAIL pp_commit commits=%0d pending=%b want 1/0", commit_cnt - c0, pending);
      end
      clear_logs();
   endtask

   task automatic test_reset_mid_drain();
      int c0;
      logic [15:0] a, d;
      set_vs(1'b1, 3);
      c0 = commit_cnt;
      for (int i = 0; i < 6; i++) begin
         a = 16'($urandom);
         d = 16'($urandom);
         drive_req(a, d);
         model_q.push_back({a, d});
      end
      drop_req();
      @(negedge clk);
      vga_vs = 1'b0;
      for (int i = 0; i < 20 && mem_we !== 1'b1; i++) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (mem_we !== 1'b0 || pending !== 1'b0) begin
         failures++;
         $display("FAIL rmd_after mem_we=%b pending=%b want 0/0", mem_we, pending);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (obs_q.size() != 1) begin
         failures++;
         $display("FAIL rmd_count got=%0d want=1", obs_q.size());
      end else if (obs_q[0] !== model_q[0]) begin
         failures++;
         $display("FAIL rmd_value got=%h want=%h", obs_q[0], model_q[0]);
      end
      checks++;
      if (commit_cnt != c0 || mem_addr !== 16'h0 || mem_data !== 16'h0) begin
         failures++;
         $display("FAIL rmd_state commits=%0d addr=%h data=%h want 0/0/0",
                  commit_cnt - c0, mem_addr, mem_data);
      end
      clear_logs();
   endtask

   initial begin
      checks     = 0;
      failures   = 0;
      cyc        = 0;
      commit_cnt = 0;
      test_reset();
      test_latency();
      test_deferred();
      test_full();
      test_window_close();
      test_push_pop();
      test_reset_mid_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
